// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions: word format, saturation limits and divider FSM states.
package fixed_point_pkg;
  localparam int WORD_W = 16;
  localparam int FRAC   = WORD_W / 2;

  localparam logic [WORD_W-1:0] MAX_POS = {1'b0, {(WORD_W-1){1'b1}}};
  localparam logic [WORD_W-1:0] MAX_NEG = {1'b1, {(WORD_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t;
endpackage

// File: rtl/fixed_division_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_in_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);
  logic [W:0] trial;

  assign trial   = {rem_i, bit_in_i};
  assign q_bit_o = (trial >= {1'b0, divisor_i});
  // The remainder is always below the divisor, so the low W bits of the difference are exact.
  assign rem_o   = q_bit_o ? (trial[W-1:0] - divisor_i) : trial[W-1:0];
endmodule

// File: rtl/fixed_division.sv
// Iterative signed Q(N/2).(N/2) divider: restoring division over 3N/2 cycles, then saturate and sign.
module fixed_division
  import fixed_point_pkg::*;
#(
  parameter int N = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Result,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic         overflow
);
  localparam int QW = 3 * N / 2;
  localparam int CW = $clog2(QW + 1);
  localparam logic [QW-1:0] POS_LIM = QW'(MAX_POS);
  localparam logic [QW-1:0] NEG_LIM = QW'(MAX_NEG);

  function automatic logic [N-1:0] mag(input logic [N-1:0] x);
    return x[N-1] ? (~x + 1'b1) : x;
  endfunction

  div_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           dz_q, dz_d, ovf_q, ovf_d;
  logic [N-1:0]   result_q, result_d;
  logic           load;

  logic [N-1:0]   a_q, b_q, divisor_q, rem_q;
  logic           neg_q;
  logic [QW-1:0]  dq_q;
  logic [N-1:0]   step_rem;
  logic           step_q;

  // Dividend bits leave from the top of dq_q while quotient bits enter at the bottom.
  div_step #(.W(N)) u_step (
    .rem_i    (rem_q),
    .bit_in_i (dq_q[QW-1]),
    .divisor_i(divisor_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    load     = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        state_d = CALC;
        cnt_d   = CW'(QW);
        busy_d  = 1'b1;
        dz_d    = 1'b0;
        ovf_d   = 1'b0;
      end
      CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (b_q == '0) begin
          dz_d     = 1'b1;
          result_d = (a_q == '0) ? '0 : (a_q[N-1] ? MAX_NEG : MAX_POS);
        end else if (!neg_q && dq_q > POS_LIM) begin
          ovf_d    = 1'b1;
          result_d = MAX_POS;
        end else if (neg_q && dq_q > NEG_LIM) begin
          ovf_d    = 1'b1;
          result_d = MAX_NEG;
        end else begin
          result_d = neg_q ? -dq_q[N-1:0] : dq_q[N-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  // Operand/iteration datapath: p0 latch on accept, then one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q       <= A;
      b_q       <= B;
      neg_q     <= A[N-1] ^ B[N-1];
      divisor_q <= mag(B);
      rem_q     <= '0;
      dq_q      <= {mag(A), {(QW-N){1'b0}}};
    end else if (state_q == CALC) begin
      rem_q <= step_rem;
      dq_q  <= {dq_q[QW-2:0], step_q};
    end
  end

  assign Result   = result_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_fixed_division.sv
// Directed-vector bench for fixed_division (N=16).
module tb_fixed_division;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] Result;
  logic        busy, done, div_zero, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fixed_division #(.N(16)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Result(Result), .busy(busy), .done(done),
    .div_zero(div_zero), .overflow(overflow)
  );

  localparam int NV = 11;
  logic [15:0] va  [NV] = '{16'h0300, 16'hFD00, 16'h0100, 16'hFF00, 16'h0500, 16'h8000,
                            16'h0000, 16'h7F00, 16'h8000, 16'h8000, 16'h0000};
  logic [15:0] vb  [NV] = '{16'h0200, 16'h0200, 16'h0300, 16'h0300, 16'h0000, 16'h0000,
                            16'h0000, 16'h0080, 16'h0100, 16'hFF00, 16'h0300};
  logic [15:0] vr  [NV] = '{16'h0180, 16'hFE80, 16'h0055, 16'hFFAB, 16'h7FFF, 16'h8000,
                            16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000};
  logic        vdz [NV] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
  logic        vov [NV] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};

  // Called 1ns after a rising edge with the divider idle; returns sampled at the done cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy_cnt);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({Result, busy, done, div_zero, overflow} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got R=%h busy=%b done=%b dz=%b ovf=%b, want all 0",
               Result, busy, done, div_zero, overflow);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_vectors();
    int lat, bc;
    for (int i = 0; i < NV; i++) begin
      run_op(va[i], vb[i], lat, bc);
      n_tests++;
      if (lat !== 25) begin
        n_fail++;
        $display("FAIL latency[%0d]: got %0d cycles, want 25", i, lat);
      end
      n_tests++;
      if (Result !== vr[i]) begin
        n_fail++;
        $display("FAIL result[%0d] A=%h B=%h: got %h, want %h", i, va[i], vb[i], Result, vr[i]);
      end
      n_tests++;
      if (div_zero !== vdz[i] || overflow !== vov[i]) begin
        n_fail++;
        $display("FAIL flags[%0d]: got dz=%b ovf=%b, want dz=%b ovf=%b",
                 i, div_zero, overflow, vdz[i], vov[i]);
      end
      n_tests++;
      if (bc !== 25 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_window[%0d]: high %0d cycles, busy at done=%b, want 25 and 0", i, bc, busy);
      end
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b0 || Result !== vr[i]) begin
        n_fail++;
        $display("FAIL done_pulse[%0d]: done=%b R=%h after one cycle, want 0 and %h held",
                 i, done, Result, vr[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, seen;
    A = 16'h0300; B = 16'h0200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    A = 16'h0100; B = 16'h0300; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat !== 25 || Result !== 16'h0180) begin
      n_fail++;
      $display("FAIL ignore_start: got lat=%0d R=%h, want 25 and 0180", lat, Result);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (busy || done) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL start_not_queued: activity on %0d cycles, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, t1, t2;
    A = 16'h0400; B = 16'h0200; start = 1'b1;
    cyc = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        if (t1 < 0) t1 = cyc; else t2 = cyc;
        n_tests++;
        if (Result !== 16'h0200) begin
          n_fail++;
          $display("FAIL b2b_result: got %h, want 0200", Result);
        end
      end
    end
    start = 1'b0;
    n_tests++;
    if (t2 - t1 !== 26) begin
      n_fail++;
      $display("FAIL b2b_spacing: got done at %0d and %0d, want 26 apart", t1, t2);
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_release: busy=%b after start dropped, want 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    int lat, bc, seen;
    A = 16'h0300; B = 16'h0500; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1 || Result !== 16'h0200) begin
      n_fail++;
      $display("FAIL pre_reset_state: busy=%b R=%h, want 1 and 0200", busy, Result);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({Result, busy, done, div_zero, overflow} !== 20'h0) begin
      n_fail++;
      $display("FAIL async_reset: got R=%h busy=%b done=%b dz=%b ovf=%b, want all 0",
               Result, busy, done, div_zero, overflow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: activity on %0d cycles, want 0", seen);
    end
    run_op(16'h0400, 16'h0200, lat, bc);
    n_tests++;
    if (lat !== 25 || Result !== 16'h0200 || div_zero !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_op: got lat=%0d R=%h dz=%b ovf=%b, want 25 0200 0 0",
               lat, Result, div_zero, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
